// File: rtl/wb_gpio_pkg.sv
// -----------------------------------------------------------------------------
// wb_gpio_pkg
// Shared definitions for the Wishbone GPIO controller: register word indices
// (selected by wb_adr_i[4:2]), the bus data width and a byte-lane helper.
// -----------------------------------------------------------------------------
package wb_gpio_pkg;

    localparam int unsigned DATA_W = 32;

    // Register word indices
    localparam logic [2:0] REG_DATA_IN    = 3'd0;
    localparam logic [2:0] REG_DATA_OUT   = 3'd1;
    localparam logic [2:0] REG_DIR        = 3'd2;
    localparam logic [2:0] REG_IRQ_MASK   = 3'd3;
    localparam logic [2:0] REG_RISE_EN    = 3'd4;
    localparam logic [2:0] REG_FALL_EN    = 3'd5;
    localparam logic [2:0] REG_IRQ_STATUS = 3'd6;
    localparam logic [2:0] REG_RESERVED   = 3'd7;

    // Expand the four byte-lane enables into a 32-bit bit mask.
    function automatic logic [DATA_W-1:0] sel_to_mask(input logic [3:0] sel);
        logic [DATA_W-1:0] mask;
        mask = {DATA_W{1'b0}};
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{sel[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_gpio_ctrl_sync_edge.sv
// -----------------------------------------------------------------------------
// gpio_sync_edge
// Two-flop synchroniser for asynchronous pad inputs, followed by a history
// flop used to detect rising and falling edges on the synchronised value.
//
// Ports:
//   clk_i    - clock
//   rst_n_i  - synchronous active-low reset
//   pad_i    - raw asynchronous pad inputs
//   sync_o   - synchronised pad value (second flop)
//   rise_o   - one-cycle pulse where sync_o went 0 -> 1
//   fall_o   - one-cycle pulse where sync_o went 1 -> 0
// -----------------------------------------------------------------------------
module gpio_sync_edge #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] prev_q;

    // Synchroniser chain and one-cycle history of the synchronised value
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_q   <= {WIDTH{1'b0}};
            s2_q   <= {WIDTH{1'b0}};
            prev_q <= {WIDTH{1'b0}};
        end else begin
            s1_q   <= pad_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign sync_o = s2_q;
    assign rise_o = s2_q & ~prev_q;
    assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/wb_gpio_ctrl.sv
// -----------------------------------------------------------------------------
// wb_gpio_ctrl
// Wishbone classic slave giving software control of GPIO pins: direction,
// output data, synchronised input readback and per-pin edge interrupts with
// write-1-to-clear status and a level interrupt output.
//
// Ports:
//   wb_clk_i    - bus clock (sole clock)
//   wb_rst_n_i  - synchronous active-low reset
//   wb_adr_i    - byte address, word select is [4:2]
//   wb_dat_i    - write data
//   wb_sel_i    - byte lane enables
//   wb_we_i     - write strobe
//   wb_cyc_i    - bus cycle
//   wb_stb_i    - slave select
//   wb_dat_o    - registered read data, valid with ack, 0 otherwise
//   wb_ack_o    - single-cycle transfer acknowledge
//   wb_err_o    - always 0
//   irq_o       - |(IRQ_STATUS & IRQ_MASK)
//   gpio_i      - raw asynchronous pad inputs
//   gpio_o      - output data to pads
//   gpio_oe_o   - per-pin output enable (1 = drive)
// -----------------------------------------------------------------------------
module wb_gpio_ctrl
    import wb_gpio_pkg::*;
#(
    parameter int unsigned GPIO_WIDTH = 8,
    parameter int unsigned ADR_WIDTH  = 5
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic [ADR_WIDTH-1:0]  wb_adr_i,
    input  logic [DATA_W-1:0]     wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [DATA_W-1:0]     wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  irq_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe_o
);

    // Byte-lane merge of write data into an existing register value.
    function automatic logic [GPIO_WIDTH-1:0] lane_merge(
        input logic [GPIO_WIDTH-1:0] old_val,
        input logic [GPIO_WIDTH-1:0] new_val,
        input logic [GPIO_WIDTH-1:0] mask
    );
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    // Register state
    logic [GPIO_WIDTH-1:0] dout_q,    dout_d;
    logic [GPIO_WIDTH-1:0] dir_q,     dir_d;
    logic [GPIO_WIDTH-1:0] mask_q,    mask_d;
    logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d;
    logic [GPIO_WIDTH-1:0] fall_en_q, fall_en_d;
    logic [GPIO_WIDTH-1:0] status_q,  status_d;
    logic                  ack_q,     ack_d;
    logic [DATA_W-1:0]     dat_q,     dat_d;

    // Bus decode
    logic                  req_s;
    logic                  wr_s;
    logic [2:0]            idx_s;
    logic [DATA_W-1:0]     bmask_s;
    logic [GPIO_WIDTH-1:0] wmask_s;
    logic [GPIO_WIDTH-1:0] wdata_s;
    logic [GPIO_WIDTH-1:0] clr_s;
    logic [GPIO_WIDTH-1:0] rd_gpio_s;
    logic [DATA_W-1:0]     rd_s;

    // Input path
    logic [GPIO_WIDTH-1:0] sync_s;
    logic [GPIO_WIDTH-1:0] rise_s;
    logic [GPIO_WIDTH-1:0] fall_s;

    // Address low bits and data bits above GPIO_WIDTH carry no information.
    logic unused_s;
    assign unused_s = ^{wb_adr_i, wb_dat_i, bmask_s};

    gpio_sync_edge #(
        .WIDTH (GPIO_WIDTH)
    ) u_sync_edge (
        .clk_i   (wb_clk_i),
        .rst_n_i (wb_rst_n_i),
        .pad_i   (gpio_i),
        .sync_o  (sync_s),
        .rise_o  (rise_s),
        .fall_o  (fall_s)
    );

    // A new request is only taken while ack is low, giving 2-cycle transfers.
    assign req_s   = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_s    = req_s & wb_we_i;
    assign idx_s   = wb_adr_i[4:2];
    assign bmask_s = sel_to_mask(wb_sel_i);
    assign wmask_s = bmask_s[GPIO_WIDTH-1:0];
    assign wdata_s = wb_dat_i[GPIO_WIDTH-1:0];

    // Register write decode, W1C clear vector and sticky status update
    always_comb begin
        dout_d    = dout_q;
        dir_d     = dir_q;
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr_s     = {GPIO_WIDTH{1'b0}};
        if (wr_s) begin
            case (idx_s)
                REG_DATA_OUT:   dout_d    = lane_merge(dout_q,    wdata_s, wmask_s);
                REG_DIR:        dir_d     = lane_merge(dir_q,     wdata_s, wmask_s);
                REG_IRQ_MASK:   mask_d    = lane_merge(mask_q,    wdata_s, wmask_s);
                REG_RISE_EN:    rise_en_d = lane_merge(rise_en_q, wdata_s, wmask_s);
                REG_FALL_EN:    fall_en_d = lane_merge(fall_en_q, wdata_s, wmask_s);
                REG_IRQ_STATUS: clr_s     = wdata_s & wmask_s;
                default:        clr_s     = {GPIO_WIDTH{1'b0}};
            endcase
        end else begin
            clr_s = {GPIO_WIDTH{1'b0}};
        end
        // Set terms are OR-ed after the clear so a coincident event wins.
        status_d = (status_q & ~clr_s) | (rise_s & rise_en_q) | (fall_s & fall_en_q);
    end

    // Read data mux, zero-extended to the bus width
    always_comb begin
        rd_s = {DATA_W{1'b0}};
        case (idx_s)
            REG_DATA_IN:    rd_gpio_s = sync_s;
            REG_DATA_OUT:   rd_gpio_s = dout_q;
            REG_DIR:        rd_gpio_s = dir_q;
            REG_IRQ_MASK:   rd_gpio_s = mask_q;
            REG_RISE_EN:    rd_gpio_s = rise_en_q;
            REG_FALL_EN:    rd_gpio_s = fall_en_q;
            REG_IRQ_STATUS: rd_gpio_s = status_q;
            default:        rd_gpio_s = {GPIO_WIDTH{1'b0}};
        endcase
        rd_s[GPIO_WIDTH-1:0] = rd_gpio_s;
    end

    // Handshake: ack for one cycle per request; data bus is 0 outside reads
    always_comb begin
        ack_d = req_s;
        if (req_s && !wb_we_i) begin
            dat_d = rd_s;
        end else begin
            dat_d = {DATA_W{1'b0}};
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            dout_q    <= {GPIO_WIDTH{1'b0}};
            dir_q     <= {GPIO_WIDTH{1'b0}};
            mask_q    <= {GPIO_WIDTH{1'b0}};
            rise_en_q <= {GPIO_WIDTH{1'b0}};
            fall_en_q <= {GPIO_WIDTH{1'b0}};
            status_q  <= {GPIO_WIDTH{1'b0}};
            ack_q     <= 1'b0;
            dat_q     <= {DATA_W{1'b0}};
        end else begin
            dout_q    <= dout_d;
            dir_q     <= dir_d;
            mask_q    <= mask_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_q;
    assign wb_err_o  = 1'b0;
    assign gpio_o    = dout_q;
    assign gpio_oe_o = dir_q;
    assign irq_o     = |(status_q & mask_q);

endmodule
